// File: rtl/qupls4_decode_queue_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for the decode queue slice.
//   cpu_types_pkg : pc_address_t (instruction address)
//   Qupls4_pkg    : DQ_DEPTH / DQ_LANES defaults, decode_bus_t bundle and the
//                   nop_bundle() helper used to fill unoccupied output lanes.
// ---------------------------------------------------------------------------
package cpu_types_pkg;
   typedef logic [31:0] pc_address_t;
endpackage

package Qupls4_pkg;
   localparam int DQ_DEPTH = 16;
   localparam int DQ_LANES = 4;

   typedef struct packed {
      logic        nop;
      logic [6:0]  opcode;
      logic [5:0]  rd;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic [23:0] imm;
   } decode_bus_t;

   // Empty lane: all fields zero, marked as a nop so rename ignores it.
   function automatic decode_bus_t nop_bundle();
      decode_bus_t b;
      b     = '0;
      b.nop = 1'b1;
      return b;
   endfunction
endpackage

// File: rtl/qupls4_decode_queue_compact.sv
// ---------------------------------------------------------------------------
// qupls4_dq_compact: lane compaction for the decode queue write side.
//   in_v  : per-lane valid from the decoder
//   slot  : per lane, number of valid lanes below it (its offset from tail)
//   nin   : total valid lanes (tail advance on an accepted write)
// ---------------------------------------------------------------------------
module qupls4_dq_compact #(
   parameter  int LANES = 4,
   localparam int SW    = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0]         in_v,
   output logic [LANES-1:0][SW-1:0] slot,
   output logic [SW-1:0]            nin
);

   // Exclusive prefix popcount: lane i lands at tail + (valid lanes below i),
   // which packs sparse valid lanes into consecutive entries in lane order.
   always_comb begin
      logic [SW-1:0] acc;
      acc  = '0;
      slot = '0;
      for (int i = 0; i < LANES; i++) begin
         slot[i] = acc;
         acc     = acc + SW'(in_v[i]);
      end
      nin = acc;
   end

endmodule

// File: rtl/qupls4_decode_queue.sv
// ---------------------------------------------------------------------------
// qupls4_decode_queue: circular queue between decode and rename.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : discard all entries (redirect); beats any handshake
//   in_v/in_db/in_ip: up to LANES decoded bundles per cycle, sparse lanes ok
//   in_rdy          : at least LANES entries free (from registered state)
//   out_v/out_db/out_ip : oldest LANES entries, lane 0 oldest, no latency
//   out_take        : entries rename consumes this cycle (clamped to count)
//   count           : current occupancy
// ---------------------------------------------------------------------------
module qupls4_decode_queue
   import Qupls4_pkg::*;
   import cpu_types_pkg::*;
#(
   parameter  int DEPTH = DQ_DEPTH,
   parameter  int LANES = DQ_LANES,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int TW    = $clog2(LANES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [LANES-1:0]        in_v,
   input  decode_bus_t [LANES-1:0] in_db,
   input  pc_address_t [LANES-1:0] in_ip,
   output logic                    in_rdy,
   output logic [LANES-1:0]        out_v,
   output decode_bus_t [LANES-1:0] out_db,
   output pc_address_t [LANES-1:0] out_ip,
   input  logic [TW-1:0]           out_take,
   output logic [CW-1:0]           count
);

   logic [AW-1:0]           head, tail;
   logic [LANES-1:0][TW-1:0] slot;
   logic [TW-1:0]           nin;
   logic [TW-1:0]           nin_acc;
   logic [CW-1:0]           take_c;
   logic [CW-1:0]           free;
   logic                    room;
   logic                    wr_en;

   decode_bus_t db_mem [DEPTH];
   pc_address_t ip_mem [DEPTH];

   qupls4_dq_compact #(.LANES(LANES)) u_compact (
      .in_v (in_v),
      .slot (slot),
      .nin  (nin)
   );

   // Space check uses occupancy only, so a full-width burst is always safe
   // and the decoder never sees in_rdy depend on its own valids.
   assign free    = CW'(DEPTH) - count;
   assign room    = free >= CW'(LANES);
   assign wr_en   = room && !flush && !rst;
   assign nin_acc = wr_en ? nin : '0;
   assign take_c  = (CW'(out_take) > count) ? count : CW'(out_take);

   // In reset the state may not be settled yet; present the empty view.
   assign in_rdy  = rst || room;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(take_c);
         tail  <= tail + AW'(nin_acc);
         count <= count + CW'(nin_acc) - take_c;
      end
   end

   // Storage is not reset: entries are only observable below count.
   // Power-of-two DEPTH makes the AW-bit add wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (in_v[i]) begin
               db_mem[tail + AW'(slot[i])] <= in_db[i];
               ip_mem[tail + AW'(slot[i])] <= in_ip[i];
            end
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_out
      logic [AW-1:0] rd_idx;
      assign rd_idx    = head + AW'(i);
      assign out_v[i]  = !rst && (count > CW'(i));
      assign out_db[i] = out_v[i] ? db_mem[rd_idx] : nop_bundle();
      assign out_ip[i] = out_v[i] ? ip_mem[rd_idx] : '0;
   end

endmodule

// File: tb/tb_qupls4_decode_queue.sv
// ---------------------------------------------------------------------------
// Bench for qupls4_decode_queue: a directed table of steps with expected
// occupancy/valid/ready, hand-written reset corner cases, then random
// traffic, all checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_qupls4_decode_queue;
   import Qupls4_pkg::*;
   import cpu_types_pkg::*;

   localparam int DEPTH = 16;
   localparam int LANES = 4;
   localparam int CW    = 5;
   localparam int TW    = 3;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush;
   logic [LANES-1:0]        in_v;
   decode_bus_t [LANES-1:0] in_db;
   pc_address_t [LANES-1:0] in_ip;
   logic                    in_rdy;
   logic [LANES-1:0]        out_v;
   decode_bus_t [LANES-1:0] out_db;
   pc_address_t [LANES-1:0] out_ip;
   logic [TW-1:0]           out_take;
   logic [CW-1:0]           count;

   qupls4_decode_queue #(.DEPTH(DEPTH), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_v(in_v), .in_db(in_db), .in_ip(in_ip), .in_rdy(in_rdy),
      .out_v(out_v), .out_db(out_db), .out_ip(out_ip),
      .out_take(out_take), .count(count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the queue contents in age order.
   pc_address_t q_ip[$];
   decode_bus_t q_db[$];

   typedef struct {
      logic       fl;
      logic [3:0] v;
      int         take;
      int         ecount;
      logic [3:0] eoutv;
      logic       erdy;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int sz;
      decode_bus_t nopb;
      nopb     = '0;
      nopb.nop = 1'b1;
      sz = q_ip.size();
      chk($sformatf("%s.count", tag), 64'(count), 64'(sz));
      chk($sformatf("%s.in_rdy", tag), 64'(in_rdy), 64'((DEPTH - sz) >= LANES));
      for (int i = 0; i < LANES; i++) begin
         chk($sformatf("%s.out_v%0d", tag, i), 64'(out_v[i]), 64'(i < sz));
         if (i < sz) begin
            chk($sformatf("%s.db%0d", tag, i), 64'(out_db[i]), 64'(q_db[i]));
            chk($sformatf("%s.ip%0d", tag, i), 64'(out_ip[i]), 64'(q_ip[i]));
         end else begin
            chk($sformatf("%s.db%0d", tag, i), 64'(out_db[i]), 64'(nopb));
         end
      end
   endtask

   task automatic drive(input logic fl, input logic [3:0] v, input int take, input pc_address_t base);
      flush    = fl;
      in_v     = v;
      out_take = TW'(take);
      for (int i = 0; i < LANES; i++) begin
         decode_bus_t b;
         b        = decode_bus_t'({$urandom, $urandom});
         b.nop    = 1'b0;
         in_db[i] = b;
         in_ip[i] = base + pc_address_t'(4 * i);
      end
   endtask

   // Next state from the rules: clear on rst/flush, else pop min(take, size)
   // then append valid lanes in lane order if LANES slots were free.
   task automatic model_step();
      int sz, t;
      bit acc;
      if (rst || flush) begin
         q_ip.delete();
         q_db.delete();
      end else begin
         sz  = q_ip.size();
         t   = (int'(out_take) < sz) ? int'(out_take) : sz;
         acc = (DEPTH - sz) >= LANES;
         repeat (t) begin
            void'(q_ip.pop_front());
            void'(q_db.pop_front());
         end
         if (acc) begin
            for (int i = 0; i < LANES; i++) begin
               if (in_v[i]) begin
                  q_ip.push_back(in_ip[i]);
                  q_db.push_back(in_db[i]);
               end
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 4'b1111, 0,  4, 4'b1111, 1'b1};
      tbl[1]  = '{1'b1, 4'b0000, 0,  0, 4'b0000, 1'b1};
      tbl[2]  = '{1'b0, 4'b0101, 0,  2, 4'b0011, 1'b1};
      tbl[3]  = '{1'b0, 4'b0000, 4,  0, 4'b0000, 1'b1};
      tbl[4]  = '{1'b0, 4'b1111, 0,  4, 4'b1111, 1'b1};
      tbl[5]  = '{1'b0, 4'b1111, 0,  8, 4'b1111, 1'b1};
      tbl[6]  = '{1'b0, 4'b1111, 0, 12, 4'b1111, 1'b1};
      tbl[7]  = '{1'b0, 4'b0011, 0, 14, 4'b1111, 1'b0};
      tbl[8]  = '{1'b0, 4'b1111, 3, 11, 4'b1111, 1'b1};
      tbl[9]  = '{1'b0, 4'b0000, 4,  7, 4'b1111, 1'b1};
      tbl[10] = '{1'b0, 4'b0000, 2,  5, 4'b1111, 1'b1};
      tbl[11] = '{1'b0, 4'b1111, 2,  7, 4'b1111, 1'b1};
      tbl[12] = '{1'b0, 4'b1111, 2,  9, 4'b1111, 1'b1};
      tbl[13] = '{1'b1, 4'b1111, 1,  0, 4'b0000, 1'b1};
      tbl[14] = '{1'b0, 4'b1000, 1,  1, 4'b0001, 1'b1};
      tbl[15] = '{1'b0, 4'b0000, 7,  0, 4'b0000, 1'b1};
      tbl[16] = '{1'b0, 4'b1111, 0,  4, 4'b1111, 1'b1};
      tbl[17] = '{1'b0, 4'b1111, 0,  8, 4'b1111, 1'b1};
      tbl[18] = '{1'b0, 4'b1111, 0, 12, 4'b1111, 1'b1};
      tbl[19] = '{1'b0, 4'b1111, 0, 16, 4'b1111, 1'b0};
      tbl[20] = '{1'b0, 4'b1111, 0, 16, 4'b1111, 1'b0};
      tbl[21] = '{1'b0, 4'b0000, 4, 12, 4'b1111, 1'b1};

      // Reset: outputs show the empty view during and after reset.
      rst = 1'b1;
      drive(1'b0, 4'b0000, 0, 32'h0);
      tick();
      check_model("rst_during");
      rst = 1'b0;
      tick();
      check_model("rst_after");

      for (int k = 0; k < 22; k++) begin
         drive(tbl[k].fl, tbl[k].v, tbl[k].take, 32'h100 + pc_address_t'(k * 32'h100));
         tick();
         chk($sformatf("tbl%0d.count", k), 64'(count), 64'(tbl[k].ecount));
         chk($sformatf("tbl%0d.out_v", k), 64'(out_v), 64'(tbl[k].eoutv));
         chk($sformatf("tbl%0d.in_rdy", k), 64'(in_rdy), 64'(tbl[k].erdy));
         check_model($sformatf("tbl%0d", k));
         if (k == 0) chk("first_ip0", 64'(out_ip[0]), 64'h100);
         if (k == 2) begin
            chk("sparse_ip0", 64'(out_ip[0]), 64'h300);
            chk("sparse_ip1", 64'(out_ip[1]), 64'h308);
            chk("sparse_nop2", 64'(out_db[2].nop), 64'd1);
            chk("sparse_nop3", 64'(out_db[3].nop), 64'd1);
         end
         if (k == 11) chk("wrap_ip3", 64'(out_ip[3]), 64'hC00);
      end

      // Reset in the middle of traffic overrides flush and handshakes.
      rst = 1'b1;
      drive(1'b1, 4'b1111, 2, 32'h5000);
      tick();
      chk("midrst.count", 64'(count), 64'd0);
      chk("midrst.out_v", 64'(out_v), 64'd0);
      chk("midrst.in_rdy", 64'(in_rdy), 64'd1);
      rst = 1'b0;
      drive(1'b0, 4'b0110, 0, 32'h6000);
      tick();
      check_model("post_midrst");

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         drive($urandom_range(0, 31) == 0, 4'($urandom), int'($urandom_range(0, 7)), $urandom);
         tick();
         check_model($sformatf("rnd%0d", n));
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
